// File: rtl/bitbakery_serial_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bitbakery_serial_rx_pkg
// Description : Shared definitions for the BitBakery serial link: byte tag
//               codes, receiver FSM state encoding, default bit timing and
//               the even-parity helper used when BITBAKERY_RX_PARITY_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
package bitbakery_serial_rx_pkg;

  // 50 MHz system clock, 115200 baud
  localparam int C_DEFAULT_CLKS_PER_BIT = 434;

  // Tag carried in byte[7:6] of every status byte
  localparam logic [1:0] C_TAG_STATUS = 2'b00;
  localparam logic [1:0] C_TAG_JOGADA = 2'b01;
  localparam logic [1:0] C_TAG_CONFIG = 2'b10;
  localparam logic [1:0] C_TAG_MAP    = 2'b11;

  // Receiver FSM encoding; the numeric values are visible on the debug port
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_DECODE    = 3'd5,
    S_WAIT_IDLE = 3'd6
  } rx_state_e;

  // Even parity bit that makes the total count of ones in data+parity even
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bitbakery_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : bitbakery_rx_sync
// Description : SYNC_STAGES-deep synchroniser for the asynchronous serial
//               line, preset to the idle (high) level on reset, plus a
//               registered falling-edge detector on the synchronised bit.
// Revision    : 1.0 - initial release
// ============================================================================
module bitbakery_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_in,
  input  logic rx_i,
  output logic rx_sync_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw line through the chain; remember the previous synced bit
  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rx_sync_o = sync_q[SYNC_STAGES-1];
  assign fall_o    = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/bitbakery_serial_rx.sv
`default_nettype none
// ============================================================================
// Module      : bitbakery_serial_rx
// Description : UART receiver for the BitBakery status stream. Deserialises
//               8N1 frames (8E1 when BITBAKERY_RX_PARITY_EN is defined) and
//               decodes the 2-bit byte tag into registered game status, with
//               a tracker that flags a complete 00->01->10 status snapshot.
// Config      : `define BITBAKERY_RX_PARITY_EN to expect an even parity bit;
//               must match the transmitter build.
// Revision    : 1.0 - initial release
// ============================================================================
module bitbakery_serial_rx
  import bitbakery_serial_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = C_DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clock,
  input  logic       reset_in,
  input  logic       entrada_serial,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_error,
  output logic [1:0] minigame,
  output logic [3:0] estado,
  output logic [5:0] jogada,
  output logic       dificuldade,
  output logic [3:0] player_position,
  output logic       snapshot_valid,
  output logic [2:0] db_estado_rx
);

  localparam int              CW          = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   C_HALF_LAST = CW'((CLKS_PER_BIT / 2) - 1);

  logic w_rx;
  logic w_fall;
  logic w_tick;

  rx_state_e     state_q,       state_d;
  logic [CW-1:0] cnt_q,         cnt_d;
  logic [2:0]    bit_q,         bit_d;
  logic [7:0]    shift_q,       shift_d;
  logic [7:0]    rx_byte_q,     rx_byte_d;
  logic          byte_valid_q,  byte_valid_d;
  logic          frame_error_q, frame_error_d;
  logic [1:0]    minigame_q,    minigame_d;
  logic [3:0]    estado_q,      estado_d;
  logic [5:0]    jogada_q,      jogada_d;
  logic          dific_q,       dific_d;
  logic [3:0]    ppos_q,        ppos_d;
  logic          snap_q,        snap_d;
  logic [1:0]    expect_q,      expect_d;

  bitbakery_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clock     (clock),
    .reset_in  (reset_in),
    .rx_i      (entrada_serial),
    .rx_sync_o (w_rx),
    .fall_o    (w_fall)
  );

  // A full bit time has elapsed since the previous sample point
  assign w_tick = (cnt_q == C_BIT_LAST);

  // State, counters, shift register, decoded fields and pulses
  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      rx_byte_q     <= '0;
      byte_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      minigame_q    <= '0;
      estado_q      <= '0;
      jogada_q      <= '0;
      dific_q       <= 1'b0;
      ppos_q        <= '0;
      snap_q        <= 1'b0;
      expect_q      <= C_TAG_STATUS;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      rx_byte_q     <= rx_byte_d;
      byte_valid_q  <= byte_valid_d;
      frame_error_q <= frame_error_d;
      minigame_q    <= minigame_d;
      estado_q      <= estado_d;
      jogada_q      <= jogada_d;
      dific_q       <= dific_d;
      ppos_q        <= ppos_d;
      snap_q        <= snap_d;
      expect_q      <= expect_d;
    end
  end

  // Next-state logic; a good stop bit loads the byte and the tagged fields on
  // the edge into DECODE, so the pulses are visible during the DECODE cycle
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    rx_byte_d     = rx_byte_q;
    byte_valid_d  = 1'b0;
    frame_error_d = 1'b0;
    minigame_d    = minigame_q;
    estado_d      = estado_q;
    jogada_d      = jogada_q;
    dific_d       = dific_q;
    ppos_d        = ppos_q;
    snap_d        = 1'b0;
    expect_d      = expect_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (w_fall) begin
          state_d = S_START;
          bit_d   = '0;
        end
      end

      S_START: begin
        if (cnt_q == C_HALF_LAST) begin
          cnt_d   = '0;
          // A line back high at mid start bit was a glitch
          state_d = w_rx ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (w_tick) begin
          cnt_d   = '0;
          shift_d = {w_rx, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef BITBAKERY_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_PARITY: begin
`ifdef BITBAKERY_RX_PARITY_EN
        if (w_tick) begin
          cnt_d = '0;
          if (w_rx != even_parity(shift_q)) begin
            frame_error_d = 1'b1;
            expect_d      = C_TAG_STATUS;
            state_d       = S_WAIT_IDLE;
          end else begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        state_d = S_IDLE;
`endif
      end

      S_STOP: begin
        if (w_tick) begin
          cnt_d = '0;
          if (w_rx) begin
            state_d      = S_DECODE;
            rx_byte_d    = shift_q;
            byte_valid_d = 1'b1;
            case (shift_q[7:6])
              C_TAG_STATUS: begin
                minigame_d = shift_q[5:4];
                estado_d   = shift_q[3:0];
                expect_d   = C_TAG_JOGADA;
              end
              C_TAG_JOGADA: begin
                jogada_d = shift_q[5:0];
                expect_d = (expect_q == C_TAG_JOGADA) ? C_TAG_CONFIG : C_TAG_STATUS;
              end
              C_TAG_CONFIG: begin
                dific_d  = shift_q[4];
                ppos_d   = shift_q[3:0];
                snap_d   = (expect_q == C_TAG_CONFIG);
                expect_d = C_TAG_STATUS;
              end
              C_TAG_MAP: begin
                expect_d = C_TAG_STATUS;
              end
              default: begin
                expect_d = C_TAG_STATUS;
              end
            endcase
          end else begin
            frame_error_d = 1'b1;
            expect_d      = C_TAG_STATUS;
            state_d       = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DECODE: begin
        state_d = S_IDLE;
      end

      S_WAIT_IDLE: begin
        // Require one unbroken bit time of idle before hunting for a start bit
        if (!w_rx) begin
          cnt_d = '0;
        end else if (w_tick) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx_byte         = rx_byte_q;
  assign byte_valid      = byte_valid_q;
  assign frame_error     = frame_error_q;
  assign minigame        = minigame_q;
  assign estado          = estado_q;
  assign jogada          = jogada_q;
  assign dificuldade     = dific_q;
  assign player_position = ppos_q;
  assign snapshot_valid  = snap_q;
  assign db_estado_rx    = state_q;

endmodule
`default_nettype wire
